// File: rtl/module_status_recorder_pkg.sv
// Shared types and default constants for the ap_ready status recorder.
// The record layout here matches the default parameter set; instances with
// other widths build their own record type with the same field order.
package monitor_pkg;

    localparam int IDX_W     = 4;
    localparam int N_MON_DEF = 10;
    localparam int TS_W_DEF  = 32;
    localparam int CNT_W_DEF = 16;
    localparam int DEPTH_DEF = 16;

    typedef struct packed {
        logic [TS_W_DEF-1:0]  ts;
        logic [N_MON_DEF-1:0] mask;
    } rec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rec_state_e;

endpackage

// File: rtl/module_status_recorder_if.sv
// Record readout port: the recorder presents the FIFO head, the consumer
// acknowledges with rec_ready.
interface module_status_recorder_if #(
    parameter int N_MON = 10,
    parameter int TS_W  = 32
);
    logic             rec_valid;
    logic             rec_ready;
    logic [TS_W-1:0]  rec_ts;
    logic [N_MON-1:0] rec_mask;

    modport master (
        output rec_valid,
        output rec_ts,
        output rec_mask,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_ts,
        input  rec_mask,
        output rec_ready
    );
endinterface

// File: rtl/module_status_recorder_fifo.sv
// Synchronous record FIFO with a registered head. Pointers carry one extra
// wrap bit so full and empty are distinguished without a separate count.
// A push while full is accepted when the same cycle also pops.
module status_fifo
    import monitor_pkg::*;
#(
    parameter type rec_type = rec_t,
    parameter int  DEPTH    = DEPTH_DEF
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    push,
    input  logic    pop,
    input  rec_type din,
    output rec_type head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_nxt;
    logic [AW:0] rd_nxt;
    logic        push_ok;
    logic        pop_ok;
    rec_type     mem [DEPTH];

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign wr_nxt  = wr_ptr + (AW+1)'(push_ok);
    assign rd_nxt  = rd_ptr + (AW+1)'(pop_ok);

    // Pointer update; reset discards everything held in the FIFO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
        end
    end

    // Storage write; contents need no reset since the pointers gate them.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Head register: next head comes from the incoming record when it lands
    // in the slot about to become the head, otherwise from storage; it is
    // zeroed whenever the FIFO will be empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head <= '0;
        end else if (wr_nxt == rd_nxt) begin
            head <= '0;
        end else if (push_ok && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) begin
            head <= din;
        end else begin
            head <= mem[rd_nxt[AW-1:0]];
        end
    end

endmodule

// File: rtl/module_status_recorder.sv
// ap_ready strobe recorder: timestamps every RUN cycle in which any monitored
// module fires, queues {ts, mask} records for readout, and keeps a
// saturating pulse counter per module readable by index.
module module_status_recorder
    import monitor_pkg::*;
#(
    parameter int N_MON = N_MON_DEF,
    parameter int TS_W  = TS_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     finish,
    input  logic [N_MON-1:0]         mon_ready,
    module_status_recorder_if.master rec,
    input  logic [IDX_W-1:0]         cnt_sel,
    output logic [CNT_W-1:0]         cnt_val,
    output logic                     running,
    output logic                     done,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     ts_wrap
);

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [N_MON-1:0] mask;
    } rec_w_t;

    rec_state_e       state;
    rec_state_e       state_nxt;
    logic [TS_W-1:0]  ts;
    logic             sample;
    logic             push;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    rec_w_t           push_rec;
    rec_w_t           head_rec;
    logic [CNT_W-1:0] cnt     [N_MON];
    logic [CNT_W-1:0] cnt_ext [2**IDX_W];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign sample        = (state == RUN);
    assign push          = sample && (|mon_ready);
    assign pop           = rec.rec_valid && rec.rec_ready;
    assign drop          = push && fifo_full && !pop;
    assign push_rec.ts   = ts;
    assign push_rec.mask = mon_ready;

    assign rec.rec_valid = !fifo_empty;
    assign rec.rec_ts    = head_rec.ts;
    assign rec.rec_mask  = head_rec.mask;

    status_fifo #(
        .rec_type (rec_w_t),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_rec),
        .head  (head_rec),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: one IDLE cycle, RUN until finish, drain, then park.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = RUN;
            RUN:     if (finish) state_nxt = DRAIN;
            DRAIN:   if (fifo_empty) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered state flags, aligned with the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            running <= (state_nxt == RUN);
            done    <= (state_nxt == DONE);
        end
    end

    // Timestamp advances only in RUN; the all-ones to zero step is sticky.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts      <= '0;
            ts_wrap <= 1'b0;
        end else if (sample) begin
            ts <= ts + 1'b1;
            if (&ts) begin
                ts_wrap <= 1'b1;
            end
        end
    end

    // Per-module pulse counters; they count even when the record is dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_MON; i++) begin
                cnt[i] <= '0;
            end
        end else if (push) begin
            for (int i = 0; i < N_MON; i++) begin
                if (mon_ready[i]) begin
                    cnt[i] <= sat_inc(cnt[i]);
                end
            end
        end
    end

    // Drop bookkeeping for records refused by a full FIFO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

    // Counter array padded to the full index range; unused slots read 0.
    always_comb begin
        for (int i = 0; i < 2**IDX_W; i++) begin
            cnt_ext[i] = '0;
        end
        for (int i = 0; i < N_MON; i++) begin
            cnt_ext[i] = cnt[i];
        end
    end

    // Registered counter readback.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_val <= '0;
        end else begin
            cnt_val <= cnt_ext[cnt_sel];
        end
    end

endmodule

// File: tb/tb_module_status_recorder.sv
// Directed bench for module_status_recorder: a default-width instance for the
// recording, overflow and drain scenarios, and a 4-bit timestamp instance for
// wrap and asynchronous mid-run reset.
module tb_module_status_recorder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A: defaults
    logic        reset_a;
    logic        finish_a;
    logic [9:0]  mon_a;
    logic [3:0]  cnt_sel_a;
    logic [15:0] cnt_val_a;
    logic        running_a;
    logic        done_a;
    logic        overflow_a;
    logic [15:0] drop_a;
    logic        wrap_a;

    // Instance B: 4-bit timestamp
    logic        reset_b;
    logic        finish_b;
    logic [9:0]  mon_b;
    logic [3:0]  cnt_sel_b;
    logic [15:0] cnt_val_b;
    logic        running_b;
    logic        done_b;
    logic        overflow_b;
    logic [15:0] drop_b;
    logic        wrap_b;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    module_status_recorder_if #(.N_MON(10), .TS_W(32)) ifa ();
    module_status_recorder_if #(.N_MON(10), .TS_W(4))  ifb ();

    module_status_recorder #(
        .N_MON(10), .TS_W(32), .CNT_W(16), .DEPTH(16)
    ) dut_a (
        .clock     (clock),
        .reset     (reset_a),
        .finish    (finish_a),
        .mon_ready (mon_a),
        .rec       (ifa),
        .cnt_sel   (cnt_sel_a),
        .cnt_val   (cnt_val_a),
        .running   (running_a),
        .done      (done_a),
        .overflow  (overflow_a),
        .drop_cnt  (drop_a),
        .ts_wrap   (wrap_a)
    );

    module_status_recorder #(
        .N_MON(10), .TS_W(4), .CNT_W(16), .DEPTH(16)
    ) dut_b (
        .clock     (clock),
        .reset     (reset_b),
        .finish    (finish_b),
        .mon_ready (mon_b),
        .rec       (ifb),
        .cnt_sel   (cnt_sel_b),
        .cnt_val   (cnt_val_b),
        .running   (running_b),
        .done      (done_b),
        .overflow  (overflow_b),
        .drop_cnt  (drop_b),
        .ts_wrap   (wrap_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset A, release, and step onto RUN cycle 0 (ts = 0).
    task automatic restart_a(input logic fin_in_idle);
        reset_a       = 1'b0;
        finish_a      = 1'b0;
        mon_a         = '0;
        ifa.rec_ready = 1'b0;
        tick();
        tick();
        finish_a = fin_in_idle;
        reset_a  = 1'b1;
        tick();
        finish_a = 1'b0;
    endtask

    logic [9:0] drain_mask [3];

    initial begin
        reset_a = 1'b0; finish_a = 1'b0; mon_a = '0; cnt_sel_a = '0; ifa.rec_ready = 1'b0;
        reset_b = 1'b0; finish_b = 1'b0; mon_b = '0; cnt_sel_b = '0; ifb.rec_ready = 1'b0;
        drain_mask[0] = 10'h001;
        drain_mask[1] = 10'h001;
        drain_mask[2] = 10'h002;

        // Reset state
        tick();
        tick();
        check("rst_valid",    64'(ifa.rec_valid), 64'd0);
        check("rst_running",  64'(running_a),     64'd0);
        check("rst_done",     64'(done_a),        64'd0);
        check("rst_overflow", 64'(overflow_a),    64'd0);
        check("rst_wrap",     64'(wrap_a),        64'd0);
        check("rst_ts",       64'(ifa.rec_ts),    64'd0);
        check("rst_mask",     64'(ifa.rec_mask),  64'd0);
        check("rst_cnt_val",  64'(cnt_val_a),     64'd0);
        check("rst_drop",     64'(drop_a),        64'd0);

        // Strobes 0x004 on RUN cycles 3 and 7; finish held during IDLE is ignored
        restart_a(1'b1);
        check("idle_finish_running", 64'(running_a), 64'd1);
        ifa.rec_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            mon_a = (k == 3 || k == 7) ? 10'h004 : 10'h000;
            tick();
            check("t1_valid", 64'(ifa.rec_valid), (k == 3 || k == 7) ? 64'd1 : 64'd0);
            if (k == 3 || k == 7) begin
                check("t1_ts",   64'(ifa.rec_ts),   64'(k));
                check("t1_mask", 64'(ifa.rec_mask), 64'h004);
            end
        end
        mon_a     = '0;
        cnt_sel_a = 4'd2;
        tick();
        check("t1_cnt2", 64'(cnt_val_a), 64'd2);

        // All-ones strobe at ts 10, then read back every counter
        mon_a = 10'h3FF;
        tick();
        check("t2_valid", 64'(ifa.rec_valid), 64'd1);
        check("t2_ts",    64'(ifa.rec_ts),    64'd10);
        check("t2_mask",  64'(ifa.rec_mask),  64'h3FF);
        mon_a = '0;
        for (int i = 0; i < 10; i++) begin
            cnt_sel_a = 4'(i);
            tick();
            check("t2_cnt", 64'(cnt_val_a), (i == 2) ? 64'd3 : 64'd1);
        end
        check("t2_popped", 64'(ifa.rec_valid), 64'd0);
        cnt_sel_a = 4'd12;
        tick();
        check("t2_cnt12", 64'(cnt_val_a), 64'd0);

        // Overflow: 20 strobes into a 16-deep FIFO with no consumer
        restart_a(1'b0);
        mon_a = 10'h001;
        for (int k = 0; k < 20; k++) tick();
        mon_a     = '0;
        cnt_sel_a = 4'd0;
        tick();
        check("t3_overflow", 64'(overflow_a),    64'd1);
        check("t3_drop",     64'(drop_a),        64'd4);
        check("t3_cnt0",     64'(cnt_val_a),     64'd20);
        ifa.rec_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t3_valid", 64'(ifa.rec_valid), 64'd1);
            check("t3_ts",    64'(ifa.rec_ts),    64'(i));
            tick();
        end
        check("t3_empty", 64'(ifa.rec_valid), 64'd0);

        // Full FIFO, then push and pop in the same cycle
        restart_a(1'b0);
        mon_a = 10'h001;
        for (int k = 0; k < 16; k++) tick();
        ifa.rec_ready = 1'b1;
        tick();
        mon_a = '0;
        check("t4_drop",     64'(drop_a),     64'd0);
        check("t4_overflow", 64'(overflow_a), 64'd0);
        for (int i = 1; i <= 16; i++) begin
            check("t4_ts", 64'(ifa.rec_ts), 64'(i));
            tick();
        end
        check("t4_empty", 64'(ifa.rec_valid), 64'd0);

        // Finish with three records pending (the finish cycle itself samples)
        restart_a(1'b0);
        mon_a = 10'h001;
        tick();
        tick();
        mon_a    = 10'h002;
        finish_a = 1'b1;
        tick();
        check("t5_running", 64'(running_a),     64'd0);
        check("t5_done0",   64'(done_a),        64'd0);
        check("t5_valid",   64'(ifa.rec_valid), 64'd1);
        finish_a      = 1'b0;
        mon_a         = 10'h3FF;
        ifa.rec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t5_ts",   64'(ifa.rec_ts),   64'(i));
            check("t5_mask", 64'(ifa.rec_mask), 64'(drain_mask[i]));
            tick();
        end
        check("t5_drained",  64'(ifa.rec_valid), 64'd0);
        check("t5_done_lat", 64'(done_a),        64'd0);
        tick();
        check("t5_done", 64'(done_a), 64'd1);
        cnt_sel_a = 4'd0;
        tick();
        check("t5_cnt0", 64'(cnt_val_a), 64'd2);
        cnt_sel_a = 4'd1;
        tick();
        check("t5_cnt1", 64'(cnt_val_a), 64'd1);
        cnt_sel_a = 4'd9;
        tick();
        check("t5_cnt9",       64'(cnt_val_a),     64'd0);
        check("t5_done_valid", 64'(ifa.rec_valid), 64'd0);
        mon_a = '0;

        // Timestamp wrap on the 4-bit instance, consumer always ready
        ifb.rec_ready = 1'b1;
        tick();
        reset_b = 1'b1;
        tick();
        mon_b = 10'h001;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("t6_ts",   64'(ifb.rec_ts), 64'(k % 16));
            check("t6_wrap", 64'(wrap_b),     (k >= 15) ? 64'd1 : 64'd0);
        end

        // Asynchronous reset mid-run, then restart from IDLE
        @(posedge clock);
        #3;
        reset_b = 1'b0;
        #1;
        check("t6_ar_valid",    64'(ifb.rec_valid), 64'd0);
        check("t6_ar_running",  64'(running_b),     64'd0);
        check("t6_ar_done",     64'(done_b),        64'd0);
        check("t6_ar_wrap",     64'(wrap_b),        64'd0);
        check("t6_ar_overflow", 64'(overflow_b),    64'd0);
        check("t6_ar_ts",       64'(ifb.rec_ts),    64'd0);
        check("t6_ar_mask",     64'(ifb.rec_mask),  64'd0);
        check("t6_ar_cnt_val",  64'(cnt_val_b),     64'd0);
        check("t6_ar_drop",     64'(drop_b),        64'd0);
        #1;
        reset_b = 1'b1;
        check("t6_idle_running", 64'(running_b), 64'd0);
        tick();
        check("t6_run_running", 64'(running_b),     64'd1);
        check("t6_idle_nosamp", 64'(ifb.rec_valid), 64'd0);
        tick();
        check("t6_first_valid", 64'(ifb.rec_valid), 64'd1);
        check("t6_first_ts",    64'(ifb.rec_ts),    64'd0);
        check("t6_first_wrap",  64'(wrap_b),        64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/module_status_recorder.md
# module_status_recorder

Synthesizable on-chip recorder for the `ap_ready` strobes of the design's non-dataflow modules. It consumes the same per-module ready signals that the cosim status monitors sample, timestamps every cycle in which any strobe fires, and buffers `{timestamp, mask}` records in a FIFO for readout over a valid/ready port. It also keeps a saturating per-module pulse counter readable by index. It sits between the accelerator instances (upstream) and the debug/readout logic (downstream).

## Interface

Parameters:
- `N_MON`, 10: number of monitored modules (1..16).
- `TS_W`, 32: timestamp width.
- `CNT_W`, 16: per-module pulse counter width.
- `DEPTH`, 16: record FIFO depth; must be a power of 2 and at least 2.

Ports (one clock; reset is asynchronous and active-low):
- `clock` in 1: sole clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `finish` in 1: end of run; level-sampled.
- `mon_ready` in N_MON: `ap_ready` strobes, bit i belongs to module i.
- `rec_valid` out 1: the FIFO head holds a record.
- `rec_ready` in 1: the consumer accepts the head record.
- `rec_ts` out TS_W: timestamp of the head record.
- `rec_mask` out N_MON: ready mask of the head record.
- `cnt_sel` in 4: counter index to read.
- `cnt_val` out CNT_W: registered value of counter `cnt_sel`.
- `running` out 1: state is RUN.
- `done` out 1: state is DONE.
- `overflow` out 1: sticky; at least one record was dropped.
- `drop_cnt` out CNT_W: saturating count of dropped records.
- `ts_wrap` out 1: sticky; the timestamp has wrapped.

## Operation

- FSM states are IDLE, RUN, DRAIN and DONE.
  - Reset enters IDLE.
  - IDLE moves to RUN unconditionally after one cycle.
  - RUN moves to DRAIN on a cycle with `finish`=1.
  - DRAIN moves to DONE when the FIFO is empty.
  - DONE holds until reset.
- Sampling happens only in RUN, including the cycle in which `finish`=1. No sampling occurs in IDLE, DRAIN or DONE.
- Timestamp `ts` is 0 on the first RUN cycle and increments by 1 every RUN cycle, modulo 2^TS_W. The step from all-ones to 0 sets `ts_wrap`. `ts` freezes outside RUN.
- On a RUN cycle with `mon_ready` != 0:
  - Push the record `{ts, mon_ready}`.
  - For each set bit i, increment counter i, saturating at 2^CNT_W-1.
- Push when the FIFO is full:
  - If the same cycle pops (`rec_valid && rec_ready`), the push is accepted.
  - Otherwise the record is dropped, `overflow` is set, and `drop_cnt` increments (saturating). Counters still increment.
- Pop: when `rec_valid && rec_ready` on a clock edge, the head advances.
- `cnt_val` returns 0 for `cnt_sel` >= N_MON.
- Reset mid-run: all state is cleared immediately and FIFO contents are discarded.

## Timing

- Reset values:
  - `rec_valid`, `running`, `done`, `overflow`, `ts_wrap` are 0.
  - `rec_ts`, `rec_mask`, `cnt_val`, `drop_cnt` are 0.
  - All counters are 0.
- Push-to-visible latency is 1 cycle. A strobe sampled at edge t gives `rec_valid`=1 after edge t, with head data stable while `rec_valid && !rec_ready`.
- `cnt_val` latency is 1 cycle from `cnt_sel`. A counter updated at edge t reads back the new value when selected at t+1.
- `running` and `done` are registered copies of the state; `done` rises the cycle after the last pop in DRAIN.
- `finish`=1 in IDLE is ignored. The first RUN cycle follows regardless.
- Records in the FIFO are ordered by strictly increasing `ts`, except across a wrap.

## Structure

- Package `monitor_pkg` holds:
  - `rec_t` struct (`ts`, `mask`).
  - `rec_state_e` enum (IDLE, RUN, DRAIN, DONE).
  - Constant `IDX_W`=4.
  - Default parameter constants.
- Sub-module `status_fifo`: synchronous FIFO of `rec_t`, DEPTH entries.
  - Read and write pointers are log2(DEPTH)+1 bits wide.
  - Ports: `full`, `empty`, `push`, `pop`, and registered head output.
  - Same-cycle push+pop when full is supported.
- The top holds the FSM, timestamp, counter array, drop logic and counter read mux.

## Test plan

- Reset, then pulse `mon_ready`=10'h004 on RUN cycles 3 and 7, with `rec_ready`=1 -> records {3,0x004} and {7,0x004}; `cnt_sel`=2 gives 2.
- Pulse `mon_ready`=10'h3FF on one cycle -> one record with mask 0x3FF; every counter 0..9 reads 1; `cnt_sel`=12 reads 0.
- Hold `rec_ready`=0 and fire 20 strobes with DEPTH=16 -> 16 records kept (ts 0..15), `overflow`=1, `drop_cnt`=4.
- Full FIFO, then push+pop in the same cycle -> push accepted, `drop_cnt` unchanged.
- Raise `finish` with 3 records pending and `rec_ready`=1 -> `running` falls, the 3 records drain, `done`=1 the cycle after the last pop; later strobes leave counters unchanged.
- TS_W=4, strobe on every cycle for 20 RUN cycles -> `ts_wrap`=1 at ts 15->0. Assert `reset` low mid-run -> all outputs 0 asynchronously, and the FSM restarts from IDLE on release.
